// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first, one bit per clock, with a start/busy/done handshake.
// Each sum bit is built from the composite XOR gate; results are registered until the next add completes.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Composite XOR made of four NANDs, mirroring the gate-level library cell.
    function automatic logic xor2(input logic x, input logic y);
        logic n;
        n = ~(x & y);
        return ~(~(x & n) & ~(y & n));
    endfunction

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (z & (x | y));
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    count_r;
    logic             carry_r;
    logic             cmsb_r;
    logic             cout_r;
    logic             overflow_r;
    logic             bit_s;
    logic             carry_next_s;

    // Full-adder slice for the bit currently at the bottom of the operand registers.
    always_comb begin
        bit_s        = xor2(xor2(op_a_r[0], op_b_r[0]), carry_r);
        carry_next_s = maj3(op_a_r[0], op_b_r[0], carry_r);
    end

    // Handshake FSM plus operand/result datapath; result registers move only on the last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            op_a_r     <= {WIDTH{1'b0}};
            op_b_r     <= {WIDTH{1'b0}};
            shift_r    <= {WIDTH{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            count_r    <= {CW{1'b0}};
            carry_r    <= 1'b0;
            cmsb_r     <= 1'b0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_a_r  <= a;
                        op_b_r  <= b;
                        carry_r <= cin;
                        count_r <= {CW{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    shift_r <= {bit_s, shift_r[WIDTH-1:1]};
                    op_a_r  <= {1'b0, op_a_r[WIDTH-1:1]};
                    op_b_r  <= {1'b0, op_b_r[WIDTH-1:1]};
                    carry_r <= carry_next_s;
                    count_r <= count_r + CW'(1);
                    // The carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (count_r == CW'(WIDTH - 2)) begin
                        cmsb_r <= carry_next_s;
                    end else begin
                        cmsb_r <= cmsb_r;
                    end
                    if (count_r == CW'(WIDTH - 1)) begin
                        state_r    <= ST_DONE;
                        sum_r      <= {bit_s, shift_r[WIDTH-1:1]};
                        cout_r     <= carry_next_s;
                        overflow_r <= xor2(carry_next_s, cmsb_r);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_r == ST_RUN);
    assign done     = (state_r == ST_DONE);
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder, LSB first, one bit per clock.
- Sits directly downstream of the composite XOR gate and consumes its output: each bit's sum is XOR(XOR(a_i, b_i), carry). Carry is the majority of a_i, b_i and carry.
- Gives the ALU/Hack datapath a low-area adder alternative to the combinational Add16, and exercises the composite gates inside a clocked stage.
- The result is registered and presented with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..32.
- CW, 5, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk      input   1      system clock; all state updates on the rising edge.
- reset_n  input   1      asynchronous, active-low reset.
- start    input   1      request an add; sampled only when busy=0.
- a        input   WIDTH  operand A; captured on the accepted start edge only.
- b        input   WIDTH  operand B; captured on the accepted start edge only.
- cin      input   1      carry-in; captured on the accepted start edge only.
- busy     output  1      1 while an add is in progress (state RUN).
- done     output  1      one-cycle pulse: sum, cout and overflow are valid.
- sum      output  WIDTH  registered result a+b+cin (mod 2^WIDTH).
- cout     output  1      carry out of the MSB.
- overflow output  1      two's-complement overflow = carry into MSB XOR cout.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0), asserted asynchronously:
  - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal operand shift registers, carry flop and bit counter are cleared.
  - Release is synchronous to the clk edge.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE or DONE, start=1 at an edge:
  - Load opA<=a, opB<=b, carry<=cin, count<=0; go to RUN.
  - sum, cout and overflow keep their previous values until the add completes.
- IDLE or DONE, start=0:
  - DONE goes to IDLE; IDLE stays in IDLE.
  - Outputs hold.
- RUN, every edge:
  - s = XOR(XOR(opA[0], opB[0]), carry).
  - Shift s into the MSB of the sum shift register; shift opA and opB right by 1.
  - carry <= (opA[0]&opB[0]) | (carry&(opA[0]|opB[0])).
  - count <= count+1.
  - On the edge where count==WIDTH-2, also record cmsb <= the carry being produced, which is the carry into the MSB.
  - On the edge where count==WIDTH-1 (last bit):
    - go to DONE;
    - cout <= new carry;
    - overflow <= new carry XOR cmsb.
- start while busy=1 is ignored; a, b and cin changes during RUN have no effect.
- Latency:
  - Accepted start at edge E0.
  - Bits are processed at edges E1..E_WIDTH.
  - done=1 in the cycle after edge E_WIDTH; total WIDTH+1 edges from start to done.
- done is high for exactly one cycle.
- Back-to-back operation: a start during the DONE cycle is accepted, giving a WIDTH+1 cycle throughput with no idle gap.
- Result outputs hold stable from done until the next add completes.
- Reset mid-RUN aborts the add: no done pulse, and outputs return to 0.
- Carry wrap: sum is modulo 2^WIDTH; an all-ones + 1 result wraps to 0 with cout=1.

Test Plan:
- Reset, then a=0x1234, b=0x1111, cin=0, start for 1 cycle -> busy=1 for 16 cycles; done pulses at edge 17; sum=0x2345, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- a=0x0000, b=0x0000, cin=1 -> sum=0x0001. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, overflow=1.
- Start accepted; drive start=1, a=0xAAAA, b=0x5555 during RUN -> ignored; first result unchanged; done pulses exactly once.
- Start asserted in the DONE cycle with a=3, b=4 -> second done exactly 17 cycles after the first; sum=0x0007. Between the two results, sum holds the first value.
- reset_n=0 at bit 8 of an add, then release -> no done; all outputs 0; the next add computes correctly.
